// File: rtl/wb_trace_checker_if.sv
// Bus bundle between the golden-trace checker and its driver.
// slave: checker side (load/start/wb_pc in, status out); master: driver side.
interface wb_trace_checker_if #(
  parameter int AW = 8
);
  logic          clear;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          start;
  logic [31:0]   wb_pc;
  logic          busy;
  logic          pass;
  logic          fail;
  logic [1:0]    err_code;
  logic [AW:0]   match_cnt;
  logic [AW-1:0] err_idx;
  logic [31:0]   err_exp;
  logic [31:0]   err_act;

  modport master (
    output clear, load_valid, load_data,
    output start, wb_pc,
    input  busy, pass, fail, err_code,
    input  match_cnt, err_idx,
    input  err_exp, err_act
  );

  modport slave (
    input  clear, load_valid, load_data,
    input  start, wb_pc,
    output busy, pass, fail, err_code,
    output match_cnt, err_idx,
    output err_exp, err_act
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Golden-trace checker: compares each write-back PC change against a
// preloaded list of expected PCs and reports pass/fail plus divergence.
// Ports: clk, rst (async, active-low), bus (wb_trace_checker_if.slave):
//   clear/load_valid/load_data/start/wb_pc in;
//   busy/pass/fail/err_code/match_cnt/err_idx/err_exp/err_act out.
// Optional watchdog: define WB_TRACE_CHK_TIMEOUT_EN to enable err_code 2.
module wb_trace_checker #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  wb_trace_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_MIS  = 2'd1;
  localparam logic [1:0] E_TO   = 2'd2;
  localparam logic [1:0] E_OVF  = 2'd3;

  state_t        r_state;
  logic [AW:0]   r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_match;
  logic [31:0]   r_last_pc;
  logic [1:0]    r_err_code;
  logic [AW-1:0] r_err_idx;
  logic [31:0]   r_err_exp;
  logic [31:0]   r_err_act;
  logic          r_busy;
  logic          r_pass;
  logic          r_fail;
  logic [31:0]   r_mem [DEPTH];

  logic          w_idle;
  logic          w_run;
  logic          w_full;
  logic          w_start_ok;
  logic          w_load;
  logic          w_evt;
  logic          w_hit;
  logic          w_last;
  logic          w_to;
  logic [31:0]   w_rd_data;

  assign w_idle     = (r_state == S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_full     = (r_wr_ptr == (AW+1)'(DEPTH));
  assign w_start_ok = w_idle & bus.start &
                      (r_wr_ptr != '0);
  // An accepted start swallows a simultaneous load.
  assign w_load     = w_idle & bus.load_valid &
                      ~w_start_ok & ~bus.clear;
  assign w_rd_data  = r_mem[r_rd_ptr];
  assign w_evt      = w_run &
                      (bus.wb_pc != r_last_pc);
  assign w_hit      = (bus.wb_pc == w_rd_data);
  assign w_last     = ({1'b0, r_rd_ptr} ==
                       (r_wr_ptr - (AW+1)'(1)));

`ifdef WB_TRACE_CHK_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 2) ?
                       $clog2(TIMEOUT) : 1;
  logic [WDW-1:0] r_wd;
  assign w_to = w_run & ~w_evt &
                (r_wd == WDW'(TIMEOUT - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT > 0);
  assign w_to        = 1'b0;
`endif

  // Trace storage is intentionally not reset;
  // an empty write pointer makes it logically empty.
  always_ff @(posedge clk) begin
    if (w_load && !w_full)
      r_mem[r_wr_ptr[AW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_match    <= '0;
      r_last_pc  <= '0;
      r_err_code <= E_NONE;
      r_err_idx  <= '0;
      r_err_exp  <= '0;
      r_err_act  <= '0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
`ifdef WB_TRACE_CHK_TIMEOUT_EN
      r_wd       <= '0;
`endif
    end else if (bus.clear) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_match    <= '0;
      r_last_pc  <= '0;
      r_err_code <= E_NONE;
      r_err_idx  <= '0;
      r_err_exp  <= '0;
      r_err_act  <= '0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
`ifdef WB_TRACE_CHK_TIMEOUT_EN
      r_wd       <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_rd_ptr  <= '0;
            r_match   <= '0;
            r_last_pc <= '0;
            r_err_idx <= '0;
            r_err_exp <= '0;
            r_err_act <= '0;
            // Overflow code survives start.
            if (r_err_code != E_OVF)
              r_err_code <= E_NONE;
`ifdef WB_TRACE_CHK_TIMEOUT_EN
            r_wd      <= '0;
`endif
          end else if (w_load) begin
            if (w_full)
              r_err_code <= E_OVF;
            else
              r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
        S_RUN: begin
          if (w_evt) begin
            r_last_pc <= bus.wb_pc;
`ifdef WB_TRACE_CHK_TIMEOUT_EN
            r_wd      <= '0;
`endif
            if (w_hit) begin
              r_match <= r_match + 1'b1;
              if (w_last) begin
                r_state <= S_PASS;
                r_busy  <= 1'b0;
                r_pass  <= 1'b1;
              end else begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
              end
            end else begin
              r_state    <= S_FAIL;
              r_busy     <= 1'b0;
              r_fail     <= 1'b1;
              r_err_code <= E_MIS;
              r_err_idx  <= r_rd_ptr;
              r_err_exp  <= w_rd_data;
              r_err_act  <= bus.wb_pc;
            end
          end else if (w_to) begin
            r_state    <= S_FAIL;
            r_busy     <= 1'b0;
            r_fail     <= 1'b1;
            r_err_code <= E_TO;
            r_err_idx  <= r_rd_ptr;
            r_err_exp  <= w_rd_data;
            r_err_act  <= r_last_pc;
          end
`ifdef WB_TRACE_CHK_TIMEOUT_EN
          else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        S_PASS: begin
        end
        S_FAIL: begin
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.pass      = r_pass;
  assign bus.fail      = r_fail;
  assign bus.err_code  = r_err_code;
  assign bus.match_cnt = r_match;
  assign bus.err_idx   = r_err_idx;
  assign bus.err_exp   = r_err_exp;
  assign bus.err_act   = r_err_act;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: pass, mismatch, timeout,
// overflow/priority, reset and clear scenarios.
module tb_wb_trace_checker;

  localparam int DEPTH   = 256;
  localparam int AW      = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wb_trace_checker_if #(.AW(AW)) bus ();

  wb_trace_checker #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic drive_pc(input logic [31:0] pc);
    bus.wb_pc = pc;
    step();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus.busy, bus.pass, bus.fail} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags got=%b want=000",
               {bus.busy, bus.pass, bus.fail});
    end
    n_checks++;
    if (bus.err_code !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_code got=%0d want=0",
               bus.err_code);
    end
    n_checks++;
    if (bus.match_cnt !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_match got=%0d want=0",
               bus.match_cnt);
    end
    n_checks++;
    if ({bus.err_idx, bus.err_exp, bus.err_act} !== 72'd0) begin
      n_errors++;
      $display("FAIL reset_err got=%h want=0",
               {bus.err_idx, bus.err_exp, bus.err_act});
    end
  endtask

  task automatic test_clean_pass();
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h0);
    load_word(32'h4);
    load_word(32'h8);
    load_word(32'hC);
    do_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL start_busy got=%b want=1", bus.busy);
    end
    // 0x0 equals last_pc: no event, so entry 0 sees 0x4.
    drive_pc(32'h0);
    drive_pc(32'h4);
    drive_pc(32'h8);
    drive_pc(32'hC);
    n_checks++;
    if ({bus.fail, bus.err_code, bus.err_idx} !==
        {1'b1, 2'd1, 8'd0}) begin
      n_errors++;
      $display("FAIL zero_first fail/code/idx got=%b/%0d/%0d want=1/1/0",
               bus.fail, bus.err_code, bus.err_idx);
    end
    n_checks++;
    if ({bus.err_exp, bus.err_act} !== {32'h0, 32'h4}) begin
      n_errors++;
      $display("FAIL zero_first exp/act got=%h/%h want=0/4",
               bus.err_exp, bus.err_act);
    end
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h4);
    load_word(32'h8);
    load_word(32'hC);
    do_start();
    drive_pc(32'h4);
    drive_pc(32'h8);
    n_checks++;
    if ({bus.busy, bus.match_cnt} !== {1'b1, 9'd2}) begin
      n_errors++;
      $display("FAIL mid_run busy/match got=%b/%0d want=1/2",
               bus.busy, bus.match_cnt);
    end
    drive_pc(32'hC);
    n_checks++;
    if ({bus.pass, bus.busy, bus.fail} !== 3'b100) begin
      n_errors++;
      $display("FAIL pass_flags got=%b want=100",
               {bus.pass, bus.busy, bus.fail});
    end
    n_checks++;
    if ({bus.match_cnt, bus.err_code} !== {9'd3, 2'd0}) begin
      n_errors++;
      $display("FAIL pass_match/code got=%0d/%0d want=3/0",
               bus.match_cnt, bus.err_code);
    end
    drive_pc(32'h40);
    n_checks++;
    if ({bus.pass, bus.match_cnt} !== {1'b1, 9'd3}) begin
      n_errors++;
      $display("FAIL pass_sticky got=%b/%0d want=1/3",
               bus.pass, bus.match_cnt);
    end
  endtask

  task automatic test_mismatch();
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h4);
    load_word(32'h8);
    load_word(32'hC);
    do_start();
    drive_pc(32'h4);
    drive_pc(32'h10);
    n_checks++;
    if ({bus.fail, bus.err_code, bus.err_idx, bus.match_cnt} !==
        {1'b1, 2'd1, 8'd1, 9'd1}) begin
      n_errors++;
      $display("FAIL mis fail/code/idx/match got=%b/%0d/%0d/%0d want=1/1/1/1",
               bus.fail, bus.err_code, bus.err_idx, bus.match_cnt);
    end
    n_checks++;
    if ({bus.err_exp, bus.err_act} !== {32'h8, 32'h10}) begin
      n_errors++;
      $display("FAIL mis exp/act got=%h/%h want=8/10",
               bus.err_exp, bus.err_act);
    end
    bus.start = 1'b1;
    drive_pc(32'h8);
    bus.start = 1'b0;
    n_checks++;
    if ({bus.fail, bus.busy, bus.err_act} !==
        {1'b1, 1'b0, 32'h10}) begin
      n_errors++;
      $display("FAIL fail_sticky fail/busy/act got=%b/%b/%h want=1/0/10",
               bus.fail, bus.busy, bus.err_act);
    end
    do_clear();
    n_checks++;
    if ({bus.fail, bus.busy, bus.err_code, bus.err_idx,
         bus.err_exp, bus.err_act, bus.match_cnt} !== '0) begin
      n_errors++;
      $display("FAIL clear_in_fail fail=%b code=%0d idx=%0d exp=%h act=%h want=0",
               bus.fail, bus.err_code, bus.err_idx,
               bus.err_exp, bus.err_act);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h4);
    load_word(32'h8);
    do_start();
    drive_pc(32'h4);
`ifdef WB_TRACE_CHK_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    n_checks++;
    if ({bus.fail, bus.busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL to_early fail/busy got=%b/%b want=0/1",
               bus.fail, bus.busy);
    end
    step();
    n_checks++;
    if ({bus.fail, bus.err_code, bus.err_idx, bus.match_cnt} !==
        {1'b1, 2'd2, 8'd1, 9'd1}) begin
      n_errors++;
      $display("FAIL to fail/code/idx/match got=%b/%0d/%0d/%0d want=1/2/1/1",
               bus.fail, bus.err_code, bus.err_idx, bus.match_cnt);
    end
    n_checks++;
    if ({bus.err_exp, bus.err_act} !== {32'h8, 32'h4}) begin
      n_errors++;
      $display("FAIL to exp/act got=%h/%h want=8/4",
               bus.err_exp, bus.err_act);
    end
`else
    for (int i = 0; i < 3 * TIMEOUT; i++) step();
    n_checks++;
    if ({bus.busy, bus.fail, bus.err_code} !==
        {1'b1, 1'b0, 2'd0}) begin
      n_errors++;
      $display("FAIL no_wd busy/fail/code got=%b/%b/%0d want=1/0/0",
               bus.busy, bus.fail, bus.err_code);
    end
    drive_pc(32'h8);
    n_checks++;
    if ({bus.pass, bus.match_cnt} !== {1'b1, 9'd2}) begin
      n_errors++;
      $display("FAIL no_wd_pass got=%b/%0d want=1/2",
               bus.pass, bus.match_cnt);
    end
`endif
    do_clear();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++)
      load_word(32'(i * 4 + 4));
    n_checks++;
    if ({bus.err_code, bus.busy} !== {2'd3, 1'b0}) begin
      n_errors++;
      $display("FAIL ovf code/busy got=%0d/%b want=3/0",
               bus.err_code, bus.busy);
    end
    n_checks++;
    if (dut.r_wr_ptr !== 9'd256) begin
      n_errors++;
      $display("FAIL ovf_wr_ptr got=%0d want=256", dut.r_wr_ptr);
    end
    bus.wb_pc      = 32'h0;
    bus.start      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hDEAD;
    step();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    n_checks++;
    if ({bus.busy, bus.err_code} !== {1'b1, 2'd3}) begin
      n_errors++;
      $display("FAIL ovf_start busy/code got=%b/%0d want=1/3",
               bus.busy, bus.err_code);
    end
    do_clear();
    n_checks++;
    if (bus.err_code !== 2'd0) begin
      n_errors++;
      $display("FAIL ovf_clear code got=%0d want=0", bus.err_code);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h4);
    load_word(32'h8);
    bus.start      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hC;
    step();
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    drive_pc(32'h4);
    drive_pc(32'h8);
    n_checks++;
    if ({bus.pass, bus.match_cnt} !== {1'b1, 9'd2}) begin
      n_errors++;
      $display("FAIL start_wins pass/match got=%b/%0d want=1/2",
               bus.pass, bus.match_cnt);
    end
    do_clear();
    bus.clear      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'h4;
    step();
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    do_start();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_drops_load busy got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    bus.wb_pc = 32'h0;
    load_word(32'h4);
    load_word(32'h8);
    load_word(32'hC);
    do_start();
    drive_pc(32'h4);
    drive_pc(32'h8);
    n_checks++;
    if ({bus.busy, bus.match_cnt} !== {1'b1, 9'd2}) begin
      n_errors++;
      $display("FAIL pre_rst busy/match got=%b/%0d want=1/2",
               bus.busy, bus.match_cnt);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.pass, bus.fail, bus.err_code,
         bus.match_cnt} !== '0) begin
      n_errors++;
      $display("FAIL rst_async busy=%b match=%0d want=0",
               bus.busy, bus.match_cnt);
    end
    #1 rst = 1'b1;
    bus.wb_pc = 32'h0;
    do_start();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_start_ignored busy got=%b want=0", bus.busy);
    end
    load_word(32'h4);
    do_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reload_start busy got=%b want=1", bus.busy);
    end
    drive_pc(32'h4);
    n_checks++;
    if ({bus.pass, bus.match_cnt} !== {1'b1, 9'd1}) begin
      n_errors++;
      $display("FAIL reload_pass got=%b/%0d want=1/1",
               bus.pass, bus.match_cnt);
    end
    do_clear();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b0;
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.wb_pc      = '0;
    #12;
    test_reset();
    rst = 1'b1;
    step();
    test_clean_pass();
    test_mismatch();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
